rotate_lanes: RTL

Parametrised successor to the encoder's rho-step rotate unit. On `start` it walks all lanes of the state memory, reads each lane, rotates it by its fixed per-lane offset (reduced mod `W`) in a multi-bit-per-cycle shift register, and writes the result back in place. It adds three things the fixed-width unit lacks: lane-width and step-size parameters, an inverse (right-rotate) mode, and a one-cycle `done` pulse. It sits between the encoder top-level controller and the shared lane RAM, and is split into a control unit and a datapath.

---
 rtl/rotate_pkg.sv | 41 ++++
 rtl/rotate_lanes_cu.sv | 124 ++++++++++++
 rtl/rotate_lanes_dp.sv | 70 +++++++
 rtl/rotate_lanes.sv | 78 +++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// rotate_pkg: shared definitions for the rho-step lane rotate unit.
//   rot_state_e  control FSM state encoding
//   RHO_OFFS     Keccak rho offsets indexed by lane i = x + 5*y
//   rho_offset() table lookup that tolerates out-of-table indices
//   rot_cycles() rotate cycles needed for offset o with a coarse step
package rotate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_ROT,
    ST_WRITE,
    ST_DONE
  } rot_state_e;

  localparam int unsigned RHO_N = 25;

  localparam logic [5:0] RHO_OFFS [RHO_N] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  // Indices outside the table (possible with a wide lane address) map to 0.
  function automatic logic [5:0] rho_offset(input int unsigned idx);
    logic [5:0] r;
    r = '0;
    for (int unsigned k = 0; k < RHO_N; k++) begin
      if (k == idx) r = RHO_OFFS[k];
    end
    return r;
  endfunction

  function automatic int unsigned rot_cycles(input int unsigned o, input int unsigned step);
    return (o / step) + (o % step);
  endfunction

endpackage

// File: rtl/rotate_lanes_cu.sv
// rotate_lanes_cu: control unit for the lane rotate pass.
//   clk, reset        clock, asynchronous active-low reset
//   i_start, i_inv    pass request and direction (direction latched at start)
//   i_offs            current lane's offset, already reduced mod W
//   o_ready, o_done   idle indication, one-cycle completion pulse
//   o_mem_rd/o_mem_wr lane RAM strobes
//   o_lane            lane index (RAM address)
//   o_load, o_rot     datapath commands: capture read data / rotate one step
//   o_coarse          rotate by STEP this cycle (else by 1)
//   o_inv             latched direction, 1 = right rotate
module rotate_lanes_cu
  import rotate_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int STEP  = 8,
  parameter  int LANES = 25,
  parameter  int AW    = 5,
  localparam int CW    = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_inv,
  input  logic [CW-1:0] i_offs,
  output logic          o_ready,
  output logic          o_done,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_lane,
  output logic          o_load,
  output logic          o_rot,
  output logic          o_coarse,
  output logic          o_inv
);

  // STEP may equal W, so the coarse threshold needs one extra bit; the
  // truncated STEP_C is only subtracted when remaining >= STEP, which
  // cannot happen when STEP == W.
  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [AW-1:0] LAST   = AW'(LANES - 1);

  rot_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_lane,  w_lane_nxt;
  logic [CW-1:0] r_rem,   w_rem_nxt;
  logic          r_inv,   w_inv_nxt;
  logic          w_coarse;

  assign w_coarse = ({1'b0, r_rem} >= STEP_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_lane  <= '0;
      r_rem   <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_rem   <= w_rem_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_rem_nxt   = r_rem;
    w_inv_nxt   = r_inv;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_load      = 1'b0;
    o_rot       = 1'b0;
    o_coarse    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_inv_nxt   = i_inv;
          w_lane_nxt  = '0;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        o_mem_rd    = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        o_load      = 1'b1;
        w_rem_nxt   = i_offs;
        w_state_nxt = (i_offs == '0) ? ST_WRITE : ST_ROT;
      end
      ST_ROT: begin
        o_rot     = 1'b1;
        o_coarse  = w_coarse;
        w_rem_nxt = w_coarse ? (r_rem - STEP_C) : (r_rem - CW'(1));
        if (w_rem_nxt == '0) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        o_mem_wr = 1'b1;
        // The index holds at the last lane rather than wrapping past LANES-1;
        // it is cleared again when the next pass starts.
        if (r_lane == LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_lane_nxt  = r_lane + AW'(1);
          w_state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_lane = r_lane;
  assign o_inv  = r_inv;

endmodule

// File: rtl/rotate_lanes_dp.sv
// rotate_lanes_dp: datapath for the lane rotate pass.
//   clk, reset   clock, asynchronous active-low reset
//   i_lane       lane index, selects the rho offset
//   i_load       capture i_rdata into the shift register
//   i_rot        rotate the shift register this cycle
//   i_coarse     rotate by STEP (else by 1)
//   i_inv        0 = rotate left, 1 = rotate right
//   i_rdata      lane data from RAM
//   o_offs       rho offset for i_lane reduced mod W
//   o_wdata      shift register contents (rotated lane)
module rotate_lanes_dp
  import rotate_pkg::*;
#(
  parameter  int W    = 64,
  parameter  int STEP = 8,
  parameter  int AW   = 5,
  localparam int CW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_lane,
  input  logic          i_load,
  input  logic          i_rot,
  input  logic          i_coarse,
  input  logic          i_inv,
  input  logic [W-1:0]  i_rdata,
  output logic [CW-1:0] o_offs,
  output logic [W-1:0]  o_wdata
);

  // W is a power of two, so mod W is a mask of the low log2(W) bits.
  localparam logic [5:0] RHO_MASK = 6'(W - 1);

  logic [5:0]   w_rho;
  logic [W-1:0] r_shift, w_shift_nxt;

  // A rotate by W degenerates to (x << W) | (x >> 0) = x, so STEP == W is safe.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned k);
    return (x << k) | (x >> (W - k));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned k);
    return (x >> k) | (x << (W - k));
  endfunction

  assign w_rho  = rho_offset(32'(i_lane));
  assign o_offs = CW'(w_rho & RHO_MASK);

  always_comb begin
    w_shift_nxt = r_shift;
    if (i_load) begin
      w_shift_nxt = i_rdata;
    end else if (i_rot) begin
      case ({i_inv, i_coarse})
        2'b00:   w_shift_nxt = rotl(r_shift, 1);
        2'b01:   w_shift_nxt = rotl(r_shift, STEP);
        2'b10:   w_shift_nxt = rotr(r_shift, 1);
        default: w_shift_nxt = rotr(r_shift, STEP);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_shift <= '0;
    else        r_shift <= w_shift_nxt;
  end

  assign o_wdata = r_shift;

endmodule

// File: rtl/rotate_lanes.sv
// rotate_lanes: walks lanes 0..LANES-1 of the lane RAM, rotating each lane in
// place by its rho offset (mod W), left or right, STEP bits per cycle.
//   clk, reset         clock, asynchronous active-low reset
//   start, inv         begin a pass (while ready), direction (1 = right)
//   ready, done        idle, one-cycle completion pulse
//   mem_rd, mem_wr     lane RAM strobes (never both high)
//   mem_addr           lane index for read or write
//   mem_wdata          rotated lane
//   mem_rdata          lane data, valid the cycle after mem_rd
module rotate_lanes
  import rotate_pkg::*;
#(
  parameter int W     = 64,
  parameter int STEP  = 8,
  parameter int LANES = 25,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          inv,
  output logic          ready,
  output logic          done,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] w_offs;
  logic          w_load;
  logic          w_rot;
  logic          w_coarse;
  logic          w_inv;

  rotate_lanes_cu #(
    .W     (W),
    .STEP  (STEP),
    .LANES (LANES),
    .AW    (AW)
  ) u_cu (
    .clk      (clk),
    .reset    (reset),
    .i_start  (start),
    .i_inv    (inv),
    .i_offs   (w_offs),
    .o_ready  (ready),
    .o_done   (done),
    .o_mem_rd (mem_rd),
    .o_mem_wr (mem_wr),
    .o_lane   (mem_addr),
    .o_load   (w_load),
    .o_rot    (w_rot),
    .o_coarse (w_coarse),
    .o_inv    (w_inv)
  );

  rotate_lanes_dp #(
    .W    (W),
    .STEP (STEP),
    .AW   (AW)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .i_lane   (mem_addr),
    .i_load   (w_load),
    .i_rot    (w_rot),
    .i_coarse (w_coarse),
    .i_inv    (w_inv),
    .i_rdata  (mem_rdata),
    .o_offs   (w_offs),
    .o_wdata  (mem_wdata)
  );

endmodule
